// File: rtl/decode_pkg.sv
// decode_pkg: opcode/control encodings and instruction field positions for the decode stage
package decode_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_CMP, OP_VADD, OP_VSUB, OP_VMUL,
    OP_VSHL, OP_LDV, OP_STV, OP_MOVI, OP_B, OP_BEQ, OP_BNE, OP_HALT
  } opcode_e;
  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_BRANCH} ext_sel_e;
  typedef enum logic [1:0] {OPT_SCALAR, OPT_VECTOR, OPT_VS, OPT_CTRL} op_type_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_MUL, ALU_SHL} alu_ctrl_e;
  typedef enum logic [1:0] {BR_NONE, BR_ALWAYS, BR_EQ, BR_NE} branch_sel_e;
  localparam int OP_HI = 31, OP_LO = 28;
  localparam int A3_HI = 27, A3_LO = 23;
  localparam int A1_HI = 22, A1_LO = 18;
  localparam int A2_HI = 17, A2_LO = 13;
  localparam int IMM_HI = 12, IMM_LO = 0;
  localparam int IMM_W = IMM_HI - IMM_LO + 1;
  typedef struct packed {
    logic        reg_we;
    logic        alu_src;
    logic        set_flags;
    logic        mem_we;
    logic        wb_sel;
    logic        op_src;
    op_type_e    op_type;
    alu_ctrl_e   alu;
    branch_sel_e br;
    ext_sel_e    ext;
  } ctrl_t;
endpackage

// File: rtl/imm_extend.sv
// imm_extend: widens the 13-bit immediate to N bits in one of four modes
module imm_extend
  import decode_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [IMM_W-1:0] imm_i,
  input  ext_sel_e         sel_i,
  output logic [N-1:0]     ext_o
);
  logic [N-1:0] w_sx;
  assign w_sx = {{(N-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign ext_o = sel_i == EXT_ZERO ? {{(N-IMM_W){1'b0}}, imm_i} :
                 sel_i == EXT_SIGN ? w_sx :
                 sel_i == EXT_HIGH ? {imm_i, {(N-IMM_W){1'b0}}} :
                 {w_sx[N-3:0], 2'b00};
endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: instruction decode, immediate extension and the ID/EX pipeline register
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int N = 32,
  parameter int L = 8,
  parameter int V = 20
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable_i,
  input  logic [N-1:0]          instruction_i,
  input  logic                  Mem_Finished_i,
  input  logic                  Exe_Finished_i,
  input  logic [N-1:0]          RD1_S_i,
  input  logic [N-1:0]          RD2_S_i,
  input  logic [V-1:0][L-1:0]   RD1_V_i,
  input  logic [V-1:0][L-1:0]   RD2_V_i,
  output logic [4:0]            A1_o,
  output logic [4:0]            A2_o,
  output logic                  Finished_o,
  output logic [N-1:0]          RD1_S_o,
  output logic [N-1:0]          RD2_S_o,
  output logic [N-1:0]          Extend_o,
  output logic [V-1:0][L-1:0]   RD1_V_o,
  output logic [V-1:0][L-1:0]   RD2_V_o,
  output logic                  RegFile_WE_o,
  output logic                  ALUSource_o,
  output logic                  SetFlags_o,
  output logic                  MemWE_o,
  output logic                  WBSelect_o,
  output logic                  OpSource_o,
  output logic [4:0]            A3_o,
  output logic [1:0]            ALUControl_o,
  output logic [1:0]            BranchSelect_o,
  output logic [1:0]            OpType_o
);
  opcode_e      w_op;
  ctrl_t        w_ctrl;
  logic [N-1:0] w_ext;
  assign w_op = opcode_e'(instruction_i[OP_HI:OP_LO]);
  assign A1_o = instruction_i[A1_HI:A1_LO];
  assign A2_o = instruction_i[A2_HI:A2_LO];
  // memory ops wait on MEM, vector ALU ops on EXE; HALT never lets ID advance
  assign Finished_o = (w_op == OP_LDV || w_op == OP_STV) ? Mem_Finished_i :
                      (w_op inside {OP_VADD, OP_VSUB, OP_VMUL, OP_VSHL}) ? Exe_Finished_i :
                      w_op != OP_HALT;
  always_comb begin
    w_ctrl = '0;
    case (w_op)
      OP_ADD:  w_ctrl.reg_we = 1'b1;
      OP_SUB:  begin w_ctrl.reg_we = 1'b1; w_ctrl.alu = ALU_SUB; end
      OP_ADDI: begin w_ctrl.reg_we = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.ext = EXT_SIGN; end
      OP_CMP:  begin w_ctrl.set_flags = 1'b1; w_ctrl.alu = ALU_SUB; end
      OP_VADD: begin w_ctrl.reg_we = 1'b1; w_ctrl.op_type = OPT_VECTOR; end
      OP_VSUB: begin w_ctrl.reg_we = 1'b1; w_ctrl.op_type = OPT_VECTOR; w_ctrl.alu = ALU_SUB; end
      OP_VMUL: begin w_ctrl.reg_we = 1'b1; w_ctrl.op_type = OPT_VECTOR; w_ctrl.alu = ALU_MUL; end
      OP_VSHL: begin
        w_ctrl.reg_we = 1'b1; w_ctrl.op_type = OPT_VS; w_ctrl.alu = ALU_SHL; w_ctrl.alu_src = 1'b1;
      end
      OP_LDV:  begin
        w_ctrl.reg_we = 1'b1; w_ctrl.wb_sel = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.op_type = OPT_VECTOR;
      end
      OP_STV:  begin w_ctrl.mem_we = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.op_type = OPT_VECTOR; end
      OP_MOVI: begin w_ctrl.reg_we = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.op_src = 1'b1; end
      OP_B:    begin w_ctrl.br = BR_ALWAYS; w_ctrl.op_type = OPT_CTRL; w_ctrl.ext = EXT_BRANCH; end
      OP_BEQ:  begin w_ctrl.br = BR_EQ; w_ctrl.op_type = OPT_CTRL; w_ctrl.ext = EXT_BRANCH; end
      OP_BNE:  begin w_ctrl.br = BR_NE; w_ctrl.op_type = OPT_CTRL; w_ctrl.ext = EXT_BRANCH; end
      default: ;
    endcase
  end
  imm_extend #(.N(N)) u_imm_extend (
    .imm_i(instruction_i[IMM_HI:IMM_LO]),
    .sel_i(w_ctrl.ext),
    .ext_o(w_ext)
  );
  // a cleared register is exactly a NOP bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD1_S_o <= '0;
      RD2_S_o <= '0;
      Extend_o <= '0;
      RD1_V_o <= '0;
      RD2_V_o <= '0;
      RegFile_WE_o <= 1'b0;
      ALUSource_o <= 1'b0;
      SetFlags_o <= 1'b0;
      MemWE_o <= 1'b0;
      WBSelect_o <= 1'b0;
      OpSource_o <= 1'b0;
      A3_o <= '0;
      ALUControl_o <= '0;
      BranchSelect_o <= '0;
      OpType_o <= '0;
    end else if (enable_i) begin
      RD1_S_o <= RD1_S_i;
      RD2_S_o <= RD2_S_i;
      Extend_o <= w_ext;
      RD1_V_o <= RD1_V_i;
      RD2_V_o <= RD2_V_i;
      RegFile_WE_o <= w_ctrl.reg_we;
      ALUSource_o <= w_ctrl.alu_src;
      SetFlags_o <= w_ctrl.set_flags;
      MemWE_o <= w_ctrl.mem_we;
      WBSelect_o <= w_ctrl.wb_sel;
      OpSource_o <= w_ctrl.op_src;
      A3_o <= instruction_i[A3_HI:A3_LO];
      ALUControl_o <= w_ctrl.alu;
      BranchSelect_o <= w_ctrl.br;
      OpType_o <= w_ctrl.op_type;
    end
  end
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: table-driven decode vectors plus reset, stall and lane sequences
module tb_decode_ctrl_stage;
  import decode_pkg::*;
  localparam int N = 32, L = 8, V = 20;
  logic CLK = 1'b0, RST = 1'b0, enable_i = 1'b0;
  logic [N-1:0] instruction_i = '0, RD1_S_i = '0, RD2_S_i = '0;
  logic Mem_Finished_i = 1'b0, Exe_Finished_i = 1'b0;
  logic [V-1:0][L-1:0] RD1_V_i = '0, RD2_V_i = '0, RD1_V_o, RD2_V_o;
  logic [4:0] A1_o, A2_o, A3_o;
  logic Finished_o, RegFile_WE_o, ALUSource_o, SetFlags_o, MemWE_o, WBSelect_o, OpSource_o;
  logic [N-1:0] RD1_S_o, RD2_S_o, Extend_o;
  logic [1:0] ALUControl_o, BranchSelect_o, OpType_o;
  logic [12:0] x_imm = '0;
  ext_sel_e x_sel = EXT_ZERO;
  logic [N-1:0] x_ext;
  int checks = 0, failures = 0;
  decode_ctrl_stage #(.N(N), .L(L), .V(V)) dut (
    .CLK(CLK), .RST(RST), .enable_i(enable_i), .instruction_i(instruction_i),
    .Mem_Finished_i(Mem_Finished_i), .Exe_Finished_i(Exe_Finished_i),
    .RD1_S_i(RD1_S_i), .RD2_S_i(RD2_S_i), .RD1_V_i(RD1_V_i), .RD2_V_i(RD2_V_i),
    .A1_o(A1_o), .A2_o(A2_o), .Finished_o(Finished_o),
    .RD1_S_o(RD1_S_o), .RD2_S_o(RD2_S_o), .Extend_o(Extend_o),
    .RD1_V_o(RD1_V_o), .RD2_V_o(RD2_V_o),
    .RegFile_WE_o(RegFile_WE_o), .ALUSource_o(ALUSource_o), .SetFlags_o(SetFlags_o),
    .MemWE_o(MemWE_o), .WBSelect_o(WBSelect_o), .OpSource_o(OpSource_o),
    .A3_o(A3_o), .ALUControl_o(ALUControl_o), .BranchSelect_o(BranchSelect_o), .OpType_o(OpType_o)
  );
  imm_extend #(.N(N)) u_ext (.imm_i(x_imm), .sel_i(x_sel), .ext_o(x_ext));
  always #5 CLK = ~CLK;
  logic [11:0] ctl;
  assign ctl = {RegFile_WE_o, ALUSource_o, SetFlags_o, MemWE_o, WBSelect_o, OpSource_o,
                OpType_o, ALUControl_o, BranchSelect_o};
  typedef struct {
    logic [3:0] op; logic [4:0] a3, a1, a2; logic [12:0] imm;
    logic mf, ef, fin; logic [11:0] ctl; logic [31:0] ext;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic [3:0] op, input logic [4:0] a3, a1, a2, input logic [12:0] imm,
                     input logic mf, ef, fin, input logic [11:0] c, input logic [31:0] ext);
    vec_t v;
    v.op = op; v.a3 = a3; v.a1 = a1; v.a2 = a2; v.imm = imm;
    v.mf = mf; v.ef = ef; v.fin = fin; v.ctl = c; v.ext = ext;
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " ctl"}, 160'(ctl), 160'(0));
    chk({tag, " A3"}, 160'(A3_o), 160'(0));
    chk({tag, " Extend"}, 160'(Extend_o), 160'(0));
    chk({tag, " RD_S"}, 160'({RD1_S_o, RD2_S_o}), 160'(0));
    chk({tag, " RD1_V"}, RD1_V_o, 160'(0));
    chk({tag, " RD2_V"}, RD2_V_o, 160'(0));
  endtask
  initial begin
    logic [V-1:0][L-1:0] v1, v2;
    logic [N-1:0] s1;
    add(4'h3, 5'd1, 5'd2, 5'd3, 13'h1FFF, 0, 0, 1, 12'b110000_00_00_00, 32'hFFFFFFFF);
    add(4'h3, 5'd2, 5'd9, 5'd1, 13'h0FFF, 0, 0, 1, 12'b110000_00_00_00, 32'h00000FFF);
    add(4'h0, 5'd4, 5'd5, 5'd6, 13'h0005, 0, 0, 1, 12'b000000_00_00_00, 32'h00000005);
    add(4'h1, 5'd31, 5'd0, 5'd17, 13'h1FFF, 0, 0, 1, 12'b100000_00_00_00, 32'h00001FFF);
    add(4'h2, 5'd7, 5'd8, 5'd9, 13'h0ABC, 1, 1, 1, 12'b100000_00_01_00, 32'h00000ABC);
    add(4'h4, 5'd10, 5'd11, 5'd12, 13'h0010, 0, 0, 1, 12'b001000_00_01_00, 32'h00000010);
    add(4'h5, 5'd13, 5'd14, 5'd15, 13'h0000, 1, 0, 0, 12'b100000_01_00_00, 32'h00000000);
    add(4'h6, 5'd16, 5'd17, 5'd18, 13'h0000, 0, 1, 1, 12'b100000_01_01_00, 32'h00000000);
    add(4'h7, 5'd19, 5'd20, 5'd21, 13'h0000, 1, 0, 0, 12'b100000_01_10_00, 32'h00000000);
    add(4'h8, 5'd22, 5'd23, 5'd24, 13'h0005, 0, 1, 1, 12'b110000_10_11_00, 32'h00000005);
    add(4'h9, 5'd25, 5'd26, 5'd27, 13'h1FFF, 0, 1, 0, 12'b110010_01_00_00, 32'h00001FFF);
    add(4'hA, 5'd28, 5'd29, 5'd30, 13'h0003, 0, 1, 0, 12'b010100_01_00_00, 32'h00000003);
    add(4'hA, 5'd1, 5'd3, 5'd5, 13'h0003, 1, 0, 1, 12'b010100_01_00_00, 32'h00000003);
    add(4'hB, 5'd2, 5'd4, 5'd6, 13'h1000, 0, 0, 1, 12'b110001_00_00_00, 32'h00001000);
    add(4'hC, 5'd3, 5'd5, 5'd7, 13'h0005, 0, 0, 1, 12'b000000_11_00_01, 32'h00000014);
    add(4'hD, 5'd8, 5'd16, 5'd24, 13'h1FFF, 0, 0, 1, 12'b000000_11_00_10, 32'hFFFFFFFC);
    add(4'hE, 5'd9, 5'd18, 5'd27, 13'h1000, 0, 0, 1, 12'b000000_11_00_11, 32'hFFFFC000);
    add(4'hF, 5'd31, 5'd31, 5'd31, 13'h1FFF, 1, 1, 0, 12'b000000_00_00_00, 32'h00001FFF);
    #1 RST = 1'b1;
    #2 chk_zero("reset");
    @(negedge CLK) RST = 1'b0;
    enable_i = 1'b1;
    foreach (tbl[i]) begin
      @(negedge CLK);
      instruction_i = {tbl[i].op, tbl[i].a3, tbl[i].a1, tbl[i].a2, tbl[i].imm};
      Mem_Finished_i = tbl[i].mf;
      Exe_Finished_i = tbl[i].ef;
      s1 = 32'h1000_0000 + 32'(i * 7);
      RD1_S_i = s1;
      RD2_S_i = ~s1;
      for (int j = 0; j < V; j++) begin
        v1[j] = 8'(i * 16 + j);
        v2[j] = 8'(255 - j - i);
      end
      RD1_V_i = v1;
      RD2_V_i = v2;
      #1;
      chk($sformatf("v%0d Finished", i), 160'(Finished_o), 160'(tbl[i].fin));
      chk($sformatf("v%0d A1A2", i), 160'({A1_o, A2_o}), 160'({tbl[i].a1, tbl[i].a2}));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d ctl", i), 160'(ctl), 160'(tbl[i].ctl));
      chk($sformatf("v%0d A3", i), 160'(A3_o), 160'(tbl[i].a3));
      chk($sformatf("v%0d Extend", i), 160'(Extend_o), 160'(tbl[i].ext));
      chk($sformatf("v%0d RD_S", i), 160'({RD1_S_o, RD2_S_o}), 160'({s1, ~s1}));
      chk($sformatf("v%0d RD1_V", i), RD1_V_o, v1);
      chk($sformatf("v%0d RD2_V", i), RD2_V_o, v2);
    end
    @(negedge CLK);
    instruction_i = 32'hA00C0000;
    Mem_Finished_i = 1'b1;
    RD1_S_i = 32'd3;
    RD1_V_i = '0;
    RD1_V_i[0] = 8'h55;
    #1 chk("lane A1", 160'(A1_o), 160'(3));
    chk("lane A2", 160'(A2_o), 160'(0));
    @(posedge CLK);
    #1 chk("lane RD1_S", 160'(RD1_S_o), 160'(3));
    chk("lane RD1_V0", 160'(RD1_V_o[0]), 160'(8'h55));
    chk("lane RD1_V1", 160'(RD1_V_o[1]), 160'(0));
    chk("lane A3", 160'(A3_o), 160'(0));
    chk("lane ctl", 160'(ctl), 160'(12'b010100_01_00_00));
    @(negedge CLK);
    instruction_i = {4'h1, 5'd12, 5'd1, 5'd2, 13'h0007};
    @(posedge CLK);
    #1 chk("stall load ctl", 160'(ctl), 160'(12'b100000_00_00_00));
    @(negedge CLK);
    enable_i = 1'b0;
    instruction_i = {4'h7, 5'd20, 5'd1, 5'd2, 13'h0100};
    RD1_S_i = 32'hDEADBEEF;
    repeat (2) @(posedge CLK);
    #1 chk("stall ctl", 160'(ctl), 160'(12'b100000_00_00_00));
    chk("stall A3", 160'(A3_o), 160'(12));
    chk("stall Extend", 160'(Extend_o), 160'(7));
    chk("stall RD1_S", 160'(RD1_S_o), 160'(3));
    @(negedge CLK) enable_i = 1'b1;
    @(posedge CLK);
    #1 chk("resume OpType", 160'(OpType_o), 160'(2'b01));
    chk("resume ALU", 160'(ALUControl_o), 160'(2'b10));
    chk("resume A3", 160'(A3_o), 160'(20));
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk_zero("async reset");
    @(negedge CLK) RST = 1'b0;
    x_imm = 13'h0005;
    x_sel = EXT_ZERO;
    #1 chk("ext zero", 160'(x_ext), 160'(32'h00000005));
    x_sel = EXT_HIGH;
    #1 chk("ext high", 160'(x_ext), 160'(32'h00280000));
    x_sel = EXT_SIGN;
    x_imm = 13'h1000;
    #1 chk("ext sign", 160'(x_ext), 160'(32'hFFFFF000));
    x_sel = EXT_BRANCH;
    x_imm = 13'h1FFF;
    #1 chk("ext branch", 160'(x_ext), 160'(32'hFFFFFFFC));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
